// File: rtl/vc_fifo.sv
// Multi-VC circular input buffer: VC_NUM independent queues sharing one storage
// array, per-VC occupancy/flags, optional first-word-fall-through read data.
module vc_fifo #(
  parameter int unsigned DATA_WIDTH       = 8,
  parameter int unsigned FIFO_DEPTH_WIDTH = 2,
  parameter int unsigned VC_NUM           = 2,
  parameter int unsigned VC_ID_WIDTH      = 1,
  parameter int unsigned FWFT             = 0,
  parameter int unsigned AF_LVL           = (2 ** FIFO_DEPTH_WIDTH) - 1,
  parameter int unsigned ID               = 0
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic                                      wr_en_i,
  input  logic [VC_ID_WIDTH-1:0]                    wr_vc_i,
  input  logic [DATA_WIDTH-1:0]                     data_i,
  input  logic                                      rd_en_i,
  input  logic [VC_ID_WIDTH-1:0]                    rd_vc_i,
  output logic [DATA_WIDTH-1:0]                     data_o,
  output logic [VC_NUM-1:0]                         full_o,
  output logic [VC_NUM-1:0]                         empty_o,
  output logic [VC_NUM-1:0]                         almost_full_o,
  output logic [VC_NUM*(FIFO_DEPTH_WIDTH+1)-1:0]    count_o,
  output logic                                      overflow_o,
  output logic                                      underflow_o
);

  localparam int unsigned W       = FIFO_DEPTH_WIDTH;
  localparam int unsigned CW      = W + 1;
  localparam int unsigned DEPTH   = 2 ** W;
  localparam int unsigned AW      = VC_ID_WIDTH + W;
  localparam int unsigned ENTRIES = VC_NUM * DEPTH;

  typedef logic [CW-1:0] ptr_t;

  ptr_t [VC_NUM-1:0]     wr_ptr_q, wr_ptr_d;
  ptr_t [VC_NUM-1:0]     rd_ptr_q, rd_ptr_d;
  ptr_t [VC_NUM-1:0]     count_c;
  logic [VC_NUM-1:0]     full_c, empty_c, af_c;
  logic [DATA_WIDTH-1:0] mem_q [ENTRIES];

  logic                  wr_vc_ok_c, rd_vc_ok_c;
  logic                  wr_full_c, rd_empty_c;
  logic [W-1:0]          wr_lo_c, rd_lo_c;
  logic                  wr_acc_c, rd_acc_c;
  logic [AW-1:0]         wr_addr_c, rd_addr_c;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic [31:0]           unused_id;
  assign unused_id = ID;

  // Flags decoded from the registered pointers; MSB is the wrap bit.
  always_comb begin
    count_c = '0;
    empty_c = '0;
    full_c  = '0;
    af_c    = '0;
    for (int unsigned v = 0; v < VC_NUM; v++) begin
      count_c[v] = wr_ptr_q[v] - rd_ptr_q[v];
      empty_c[v] = (wr_ptr_q[v] == rd_ptr_q[v]);
      full_c[v]  = (wr_ptr_q[v][W] != rd_ptr_q[v][W]) &&
                   (wr_ptr_q[v][W-1:0] == rd_ptr_q[v][W-1:0]);
      af_c[v]    = (count_c[v] >= CW'(AF_LVL));
    end
  end

  // Select the addressed VC's state; an out-of-range VC id matches nothing.
  always_comb begin
    wr_vc_ok_c = 1'b0;
    rd_vc_ok_c = 1'b0;
    wr_full_c  = 1'b1;
    rd_empty_c = 1'b1;
    wr_lo_c    = '0;
    rd_lo_c    = '0;
    for (int unsigned v = 0; v < VC_NUM; v++) begin
      if (wr_vc_i == VC_ID_WIDTH'(v)) begin
        wr_vc_ok_c = 1'b1;
        wr_full_c  = full_c[v];
        wr_lo_c    = wr_ptr_q[v][W-1:0];
      end
      if (rd_vc_i == VC_ID_WIDTH'(v)) begin
        rd_vc_ok_c = 1'b1;
        rd_empty_c = empty_c[v];
        rd_lo_c    = rd_ptr_q[v][W-1:0];
      end
    end
  end

  // A full VC may still take a write when the same VC is popped this cycle.
  always_comb begin
    rd_acc_c    = rd_en_i && rd_vc_ok_c && !rd_empty_c;
    wr_acc_c    = wr_en_i && wr_vc_ok_c &&
                  (!wr_full_c || (rd_acc_c && (rd_vc_i == wr_vc_i)));
    wr_addr_c   = {wr_vc_i, wr_lo_c};
    rd_addr_c   = {rd_vc_i, rd_lo_c};
    overflow_d  = wr_en_i && !wr_acc_c;
    underflow_d = rd_en_i && !rd_acc_c;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    for (int unsigned v = 0; v < VC_NUM; v++) begin
      if (wr_acc_c && (wr_vc_i == VC_ID_WIDTH'(v))) wr_ptr_d[v] = wr_ptr_q[v] + CW'(1);
      if (rd_acc_c && (rd_vc_i == VC_ID_WIDTH'(v))) rd_ptr_d[v] = rd_ptr_q[v] + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Payload storage, deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (wr_acc_c) mem_q[wr_addr_c] <= data_i;
  end

  if (FWFT != 0) begin : g_fwft
    assign data_o = mem_q[rd_addr_c];
  end else begin : g_reg
    logic [DATA_WIDTH-1:0] data_q, data_d;

    always_comb begin
      data_d = data_q;
      if (rd_acc_c) data_d = mem_q[rd_addr_c];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) data_q <= '0;
      else         data_q <= data_d;
    end

    assign data_o = data_q;
  end

  assign full_o        = full_c;
  assign empty_o       = empty_c;
  assign almost_full_o = af_c;
  assign count_o       = count_c;
  assign overflow_o    = overflow_q;
  assign underflow_o   = underflow_q;

endmodule
